uart_cmd_seq: RTL and testbench

- Parametrised, buffered successor to the single-shot host-command UART transmitter used to drive the Segway's RX pin.
- Accepts a burst of commands into an internal FIFO and transmits them back-to-back as UART frames.
- Data width, parity and baud divisor are configurable; an optional idle gap is inserted between frames.
- Sits between the bench/host sequencing logic and the DUT RX line, so a full command script ('g', 's', ...) can be queued in one go.

---
 rtl/uart_cmd_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_uart_cmd_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_seq.sv
// -----------------------------------------------------------------------------
// uart_cmd_seq
//
// Buffered host-command UART transmitter. Commands are pushed into a small
// FIFO and sent back-to-back as UART frames:
//     start(0) | DATA_W data bits, LSB first | optional parity | stop(1)
// An optional idle-high gap can be inserted after each stop bit.
//
// Parameters
//   DATA_W   : data bits per frame (5..9)
//   DEPTH    : FIFO entries (power of 2, >= 2)
//   BAUD_DIV : clk cycles per bit (>= 2)
//   GAP_CYC  : idle-high cycles after each stop bit (0 = none)
//   PARITY   : 0 = none, 1 = even, 2 = odd
//
// Ports
//   clk      : system clock
//   rst      : synchronous reset, active-high
//   wr_en    : push wr_data into the FIFO this cycle
//   wr_data  : command to queue
//   flush    : discard all queued entries (frame in flight completes)
//   full     : FIFO holds DEPTH entries
//   empty    : FIFO holds 0 entries
//   count    : entries queued, excluding the frame in flight
//   ovf      : sticky, a write was attempted while full (cleared by flush/rst)
//   TX       : registered serial line, idle high
//   busy     : high in every state except IDLE
//   cmd_sent : one-cycle pulse on the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_cmd_seq #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int BAUD_DIV = 2604,
    parameter int GAP_CYC  = 0,
    parameter int PARITY   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       TX,
    output logic                       busy,
    output logic                       cmd_sent
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic              HAS_PAR   = (PARITY != 0);
    localparam logic              ODD_PAR   = (PARITY == 2);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_PAR   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;
    localparam logic [2:0] ST_GAP   = 3'd6;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] head_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              ovf_reg;

    logic [2:0]        state_reg;
    logic              pop;
    logic              wr_ok;
    logic              ovf_set;

    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign ovf     = ovf_reg;

    // The head entry leaves the FIFO only in LOAD. A write while full is
    // still accepted when it coincides with that pop, since a slot frees up.
    assign pop     = (state_reg == ST_LOAD);
    assign wr_ok   = wr_en && !flush && (!full || pop);
    assign ovf_set = wr_en && !flush && full && !pop;

    // Storage with a registered read. head_reg continuously tracks the entry
    // at rd_ptr; any entry is written at least one cycle before LOAD samples
    // head_reg, so the registered copy is always current when it is used.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        head_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else if (flush) begin
            // The entry popped in a same-cycle LOAD is already on its way
            // into the shift register, so the pointers can simply restart.
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [2:0]        state_next;
    logic [BAUD_W-1:0] baud_reg,  baud_next;
    logic [BIT_W-1:0]  bit_reg,   bit_next;
    logic [GAP_W-1:0]  gap_reg,   gap_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              par_reg,   par_next;
    logic              tx_reg,    tx_next;
    logic              cmd_sent_reg, cmd_sent_next;
    logic              baud_end;
    logic [2:0]        follow_state;

    assign baud_end = (baud_reg == BAUD_LAST);

    // Where to go once a frame (and its gap) is over. A same-cycle flush
    // empties the FIFO, so it must not launch another LOAD.
    assign follow_state = (!empty && !flush) ? ST_LOAD : ST_IDLE;

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        gap_next   = gap_reg;
        shift_next = shift_reg;
        par_next   = par_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!empty && !flush) begin
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                shift_next = head_reg;
                par_next   = (^head_reg) ^ ODD_PAR;
                baud_next  = '0;
                bit_next   = '0;
                state_next = ST_START;
            end

            ST_START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        state_next = HAS_PAR ? ST_PAR : ST_STOP;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            ST_PAR: begin
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = ST_STOP;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            ST_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (GAP_CYC > 0) begin
                        gap_next   = '0;
                        state_next = ST_GAP;
                    end else begin
                        state_next = follow_state;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = follow_state;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The line level is decoded from the next state so that the
        // registered TX changes on exactly the same edge as the state.
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
            ST_PAR:   tx_next = par_next;
            default:  tx_next = 1'b1;
        endcase

        cmd_sent_next = (state_next == ST_STOP) && (baud_next == BAUD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            gap_reg      <= '0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            tx_reg       <= 1'b1;
            cmd_sent_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            gap_reg      <= gap_next;
            shift_reg    <= shift_next;
            par_reg      <= par_next;
            tx_reg       <= tx_next;
            cmd_sent_reg <= cmd_sent_next;
        end
    end

    assign TX       = tx_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign cmd_sent = cmd_sent_reg;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_seq
//
// Three instances with different configurations:
//   A (sel 0): DATA_W=8 DEPTH=4 BAUD_DIV=16 GAP_CYC=0  PARITY=0
//   B (sel 1): DATA_W=8 DEPTH=2 BAUD_DIV=8  GAP_CYC=40 PARITY=2 (odd)
//   C (sel 2): DATA_W=8 DEPTH=2 BAUD_DIV=8  GAP_CYC=40 PARITY=1 (even)
// A table of single-frame vectors is run first, followed by hand-written
// sequences for burst/back-pressure, flush, reset and write-on-pop.
// Cycle offsets k in comments are relative to the first write edge (k=0).
// -----------------------------------------------------------------------------
module tb_uart_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] wr_data;
    logic [2:0] wr_en_v;

    logic       full_a, empty_a, ovf_a, tx_a, busy_a, cmd_a;
    logic [2:0] count_a;
    logic       full_b, empty_b, ovf_b, tx_b, busy_b, cmd_b;
    logic [1:0] count_b;
    logic       full_c, empty_c, ovf_c, tx_c, busy_c, cmd_c;
    logic [1:0] count_c;

    int checks = 0;
    int errors = 0;
    int mon_sel = 0;

    always #5 clk = ~clk;

    uart_cmd_seq #(.DATA_W(8), .DEPTH(4), .BAUD_DIV(16), .GAP_CYC(0), .PARITY(0)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_v[0]), .wr_data(wr_data), .flush(flush),
        .full(full_a), .empty(empty_a), .count(count_a), .ovf(ovf_a),
        .TX(tx_a), .busy(busy_a), .cmd_sent(cmd_a)
    );

    uart_cmd_seq #(.DATA_W(8), .DEPTH(2), .BAUD_DIV(8), .GAP_CYC(40), .PARITY(2)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_v[1]), .wr_data(wr_data), .flush(flush),
        .full(full_b), .empty(empty_b), .count(count_b), .ovf(ovf_b),
        .TX(tx_b), .busy(busy_b), .cmd_sent(cmd_b)
    );

    uart_cmd_seq #(.DATA_W(8), .DEPTH(2), .BAUD_DIV(8), .GAP_CYC(40), .PARITY(1)) dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en_v[2]), .wr_data(wr_data), .flush(flush),
        .full(full_c), .empty(empty_c), .count(count_c), .ovf(ovf_c),
        .TX(tx_c), .busy(busy_c), .cmd_sent(cmd_c)
    );

    // Monitor accessors for the instance selected by mon_sel.
    function automatic logic m_tx();
        case (mon_sel) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
    endfunction
    function automatic logic m_busy();
        case (mon_sel) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction
    function automatic logic m_cmd();
        case (mon_sel) 0: return cmd_a; 1: return cmd_b; default: return cmd_c; endcase
    endfunction
    function automatic logic m_full();
        case (mon_sel) 0: return full_a; 1: return full_b; default: return full_c; endcase
    endfunction
    function automatic logic m_empty();
        case (mon_sel) 0: return empty_a; 1: return empty_b; default: return empty_c; endcase
    endfunction
    function automatic logic m_ovf();
        case (mon_sel) 0: return ovf_a; 1: return ovf_b; default: return ovf_c; endcase
    endfunction
    function automatic int m_count();
        case (mon_sel) 0: return int'(count_a); 1: return int'(count_b); default: return int'(count_c); endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Entered on the first cycle of the start bit. Compares the line against
    // a UART frame built from `data`, decodes it mid-bit like a receiver,
    // and returns the cycle offset at which cmd_sent was first seen.
    // Returns on the first cycle after the frame and its gap.
    task automatic expect_frame(input string name, input logic [7:0] data, input int baud,
                                input bit has_par, input bit par_bit, input int gap,
                                output int sent_off);
        logic [10:0] bits;
        logic [10:0] rx;
        int nb;
        int wave_bad;
        int pulses;
        int k;
        nb = has_par ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        if (has_par) bits[9] = par_bit;
        rx = '0;
        wave_bad = 0;
        pulses = 0;
        sent_off = -1;
        k = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < baud; c++) begin
                if (m_tx() !== bits[b] || m_busy() !== 1'b1) wave_bad++;
                if (c == baud / 2) rx[b] = m_tx();
                if (m_cmd() === 1'b1) begin
                    pulses++;
                    if (sent_off < 0) sent_off = k;
                end
                tick();
                k++;
            end
        end
        for (int g = 0; g < gap; g++) begin
            if (m_tx() !== 1'b1 || m_busy() !== 1'b1 || m_cmd() !== 1'b0) wave_bad++;
            tick();
        end
        check_eq({name, " wave mismatches"}, wave_bad, 0);
        check_eq({name, " rx byte"}, int'(rx[8:1]), int'(data));
        check_eq({name, " cmd_sent pulses"}, pulses, 1);
        if (has_par) check_eq({name, " rx parity"}, int'(rx[9]), int'(par_bit));
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        bit         has_par;
        int         baud;
        int         gap;
        bit         exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs[9];

    // Write one byte into an idle instance and check the whole frame.
    task automatic run_vector(input string name, input vec_t v);
        int so;
        mon_sel = v.sel;
        wr_data = v.data;
        wr_en_v[v.sel] = 1'b1;
        tick();                                   // k=0 write edge
        wr_en_v = '0;
        check_eq({name, " count after write"}, m_count(), 1);
        tick();                                   // k=1 LOAD
        check_eq({name, " load tx/busy/cmd"}, int'({m_tx(), m_busy(), m_cmd()}), 3'b110);
        tick();                                   // k=2 start bit
        check_eq({name, " empty at start"}, int'(m_empty()), 1);
        expect_frame(name, v.data, v.baud, v.has_par, v.exp_par, v.gap, so);
        check_eq({name, " cmd_sent cycle"}, 2 + so, v.exp_len + 1);
        check_eq({name, " idle tx/busy"}, int'({m_tx(), m_busy()}), 2'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int so;
        int bad;
        int exp_cnt[6];
        int exp_full[6];
        int exp_ovf[6];

        vecs[0] = '{0, 8'h67, 1'b0, 16, 0,  1'b0, 160};
        vecs[1] = '{0, 8'h00, 1'b0, 16, 0,  1'b0, 160};
        vecs[2] = '{0, 8'hFF, 1'b0, 16, 0,  1'b0, 160};
        vecs[3] = '{0, 8'hA5, 1'b0, 16, 0,  1'b0, 160};
        vecs[4] = '{1, 8'h73, 1'b1, 8,  40, 1'b0, 88};   // odd,  5 ones
        vecs[5] = '{2, 8'h73, 1'b1, 8,  40, 1'b1, 88};   // even, 5 ones
        vecs[6] = '{1, 8'h00, 1'b1, 8,  40, 1'b1, 88};   // odd,  0 ones
        vecs[7] = '{2, 8'h81, 1'b1, 8,  40, 1'b0, 88};   // even, 2 ones
        vecs[8] = '{1, 8'h01, 1'b1, 8,  40, 1'b0, 88};   // odd,  1 one

        exp_cnt  = '{1, 2, 2, 3, 4, 4};
        exp_full = '{0, 0, 0, 0, 1, 1};
        exp_ovf  = '{0, 0, 0, 0, 0, 1};

        rst = 1'b1;
        flush = 1'b0;
        wr_data = '0;
        wr_en_v = '0;
        repeat (3) tick();

        // Reset state of every instance
        for (int s = 0; s < 3; s++) begin
            mon_sel = s;
            check_eq($sformatf("reset dut%0d tx/busy/cmd", s), int'({m_tx(), m_busy(), m_cmd()}), 3'b100);
            check_eq($sformatf("reset dut%0d count", s), m_count(), 0);
            check_eq($sformatf("reset dut%0d empty/full/ovf", s), int'({m_empty(), m_full(), m_ovf()}), 3'b100);
        end
        rst = 1'b0;
        tick();

        // Table-driven single frames
        for (int i = 0; i < 9; i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i]);
            tick();
        end

        // Burst of 6 writes into A (DEPTH=4): 5 accepted, 6th overflows
        mon_sel = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_data = 8'(8'h10 + i);
                    wr_en_v[0] = 1'b1;
                    tick();                       // k=i
                    check_eq($sformatf("burst k%0d count", i), m_count(), exp_cnt[i]);
                    check_eq($sformatf("burst k%0d full", i), int'(m_full()), exp_full[i]);
                    check_eq($sformatf("burst k%0d ovf", i), int'(m_ovf()), exp_ovf[i]);
                end
                wr_en_v = '0;
            end
            begin
                repeat (3) tick();                // k=2
                for (int f = 0; f < 5; f++) begin
                    expect_frame($sformatf("burst frame%0d", f), 8'(8'h10 + f), 16, 1'b0, 1'b0, 0, so);
                    if (f < 4) begin
                        check_eq($sformatf("burst load%0d tx/busy/cmd", f),
                                 int'({m_tx(), m_busy(), m_cmd()}), 3'b110);
                        tick();
                    end
                end
                check_eq("burst idle tx/busy", int'({m_tx(), m_busy()}), 2'b10);
            end
        join
        tick();

        // Flush during data bit 3 of the first of three queued frames
        check_eq("ovf sticky before flush", int'(m_ovf()), 1);
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    wr_data = 8'(8'h31 + i);
                    wr_en_v[0] = 1'b1;
                    tick();
                end
                wr_en_v = '0;                     // k=2
                repeat (67) tick();               // k=69
                flush = 1'b1;
                tick();                           // k=70, flush edge
                flush = 1'b0;
                check_eq("flush count", m_count(), 0);
                check_eq("flush empty/ovf", int'({m_empty(), m_ovf()}), 2'b10);
            end
            begin
                repeat (3) tick();
                expect_frame("flush frame", 8'h31, 16, 1'b0, 1'b0, 0, so);
                check_eq("flush idle tx/busy", int'({m_tx(), m_busy()}), 2'b10);
                bad = 0;
                for (int i = 0; i < 40; i++) begin
                    if (m_tx() !== 1'b1 || m_busy() !== 1'b0 || m_cmd() !== 1'b0) bad++;
                    tick();
                end
                check_eq("flush no further frames", bad, 0);
            end
        join

        // Reset in the middle of data bit 1 of 8'h55 (line low there)
        mon_sel = 0;
        wr_data = 8'h55;
        wr_en_v[0] = 1'b1;
        tick();                                   // k=0
        wr_en_v = '0;
        repeat (39) tick();                       // k=39
        check_eq("pre-reset tx", int'(m_tx()), 0);
        rst = 1'b1;
        tick();                                   // k=40
        rst = 1'b0;
        check_eq("mid-frame reset tx/busy/cmd", int'({m_tx(), m_busy(), m_cmd()}), 3'b100);
        check_eq("mid-frame reset count/empty", int'({m_count() == 0, m_empty()}), 2'b11);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_tx() !== 1'b1 || m_busy() !== 1'b0 || m_cmd() !== 1'b0) bad++;
        end
        check_eq("post-reset line quiet", bad, 0);
        run_vector("post-reset", vecs[0]);
        tick();

        // B (DEPTH=2): fill, then write exactly on the LOAD cycle of frame 2
        mon_sel = 1;
        fork
            begin
                wr_data = 8'h5A; wr_en_v[1] = 1'b1; tick();   // k=0
                wr_data = 8'hC3; tick();                      // k=1
                wr_data = 8'h07; tick();                      // k=2, write+pop
                wr_en_v = '0;
                check_eq("wpop fill count", m_count(), 2);
                check_eq("wpop fill full/ovf", int'({m_full(), m_ovf()}), 2'b10);
                repeat (128) tick();                          // k=130 LOAD
                check_eq("wpop load tx/busy", int'({m_tx(), m_busy()}), 2'b11);
                wr_data = 8'h99;
                wr_en_v[1] = 1'b1;
                tick();                                       // k=131 pop edge
                wr_en_v = '0;
                check_eq("wpop count", m_count(), 2);
                check_eq("wpop full/ovf", int'({m_full(), m_ovf()}), 2'b10);
            end
            begin
                repeat (3) tick();
                expect_frame("wpop frame0", 8'h5A, 8, 1'b1, 1'b1, 40, so);
                check_eq("wpop load0 tx/busy/cmd", int'({m_tx(), m_busy(), m_cmd()}), 3'b110);
                tick();
                expect_frame("wpop frame1", 8'hC3, 8, 1'b1, 1'b1, 40, so);
                check_eq("wpop load1 tx/busy/cmd", int'({m_tx(), m_busy(), m_cmd()}), 3'b110);
                tick();
                expect_frame("wpop frame2", 8'h07, 8, 1'b1, 1'b0, 40, so);
                check_eq("wpop load2 tx/busy/cmd", int'({m_tx(), m_busy(), m_cmd()}), 3'b110);
                tick();
                expect_frame("wpop frame3", 8'h99, 8, 1'b1, 1'b1, 40, so);
                check_eq("wpop idle tx/busy", int'({m_tx(), m_busy()}), 2'b10);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
